// File: rtl/gather_credit_counter_pkg.sv
// Shared types and constants for the gather credit path: flit encoding, default
// downstream buffer allocation, packet tracking state.
package gather_credit_counter_pkg;

  localparam logic [1:0] FLIT_HEAD = 2'd1;
  localparam logic [1:0] FLIT_BODY = 2'd2;
  localparam logic [1:0] FLIT_TAIL = 2'd3;

  localparam int GATHER_CREDIT_ALLOC = 32;

  typedef enum logic {
    PKT_IDLE   = 1'b0,
    PKT_ACTIVE = 1'b1
  } pkt_state_t;

endpackage

// File: rtl/gather_credit_counter_if.sv
// Bundle between flit source / credit-return wires and the credit counter.
// Optional statistics outputs exist only when GATHER_CRD_STATS_EN is defined.
interface gather_credit_counter_if #(
  parameter int RET_W = 4
);
  logic             flit_fire;
  logic [1:0]       flit_type;
  logic             crd_ret_valid;
  logic [RET_W-1:0] crd_ret_num;
  logic             clr_err;
  logic [31:0]      credit_cnt;
  logic             credit_low;
  logic             credit_full;
  logic             pkt_active;
  logic             err_underflow;
  logic             err_overflow;
  logic             err_proto;
`ifdef GATHER_CRD_STATS_EN
  logic [31:0]      crd_min;
  logic [31:0]      stall_cycles;
`endif

  modport master (
    output flit_fire, flit_type, crd_ret_valid, crd_ret_num, clr_err,
    input  credit_cnt, credit_low, credit_full, pkt_active,
    input  err_underflow, err_overflow, err_proto
`ifdef GATHER_CRD_STATS_EN
    , input crd_min, stall_cycles
`endif
  );

  modport slave (
    input  flit_fire, flit_type, crd_ret_valid, crd_ret_num, clr_err,
    output credit_cnt, credit_low, credit_full, pkt_active,
    output err_underflow, err_overflow, err_proto
`ifdef GATHER_CRD_STATS_EN
    , output crd_min, stall_cycles
`endif
  );

endinterface

// File: rtl/gather_credit_counter_pkt_tracker.sv
// HEAD..TAIL packet tracker with sticky protocol-error flag; outputs 1 cycle after
// the fire. Never stalls the flit stream, only observes it.
module gather_pkt_tracker
  import gather_credit_counter_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       flit_fire,
  input  logic [1:0] flit_type,
  input  logic       clr_err,
  output logic       pkt_active,
  output logic       err_proto
);

  pkt_state_t state, state_nxt;
  logic       proto_hit;

  always_comb begin
    state_nxt = state;
    proto_hit = 1'b0;
    if (flit_fire) begin
      case (state)
        PKT_IDLE: begin
          if (flit_type == FLIT_HEAD) state_nxt = PKT_ACTIVE;
          else                        proto_hit = 1'b1;
        end
        PKT_ACTIVE: begin
          if (flit_type == FLIT_TAIL)      state_nxt = PKT_IDLE;
          else if (flit_type == FLIT_HEAD) proto_hit = 1'b1;
        end
        default: state_nxt = PKT_IDLE;
      endcase
    end
  end

  // A new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= PKT_IDLE;
      err_proto <= 1'b0;
    end else begin
      state     <= state_nxt;
      err_proto <= (err_proto & ~clr_err) | proto_hit;
    end
  end

  assign pkt_active = (state == PKT_ACTIVE);

endmodule

// File: rtl/gather_credit_counter.sv
// Downstream gather-buffer credit counter: 1-cycle latency from fire/return to
// credit_cnt; no backpressure (errors flagged instead). Stats under GATHER_CRD_STATS_EN.
module gather_credit_counter
  import gather_credit_counter_pkg::*;
#(
  parameter int x_pos       = 0,
  parameter int y_pos       = 0,
  parameter int INIT_CREDIT = GATHER_CREDIT_ALLOC,
  parameter int RET_W       = 4,
  parameter int LOW_WM      = 14
) (
  input  logic                  clk,
  input  logic                  rstn,
  gather_credit_counter_if.slave bus
);

  localparam logic [32:0] INIT_EXT = 33'(INIT_CREDIT);
  localparam logic [32:0] LOW_EXT  = 33'(LOW_WM);

  if (INIT_CREDIT < 1 || x_pos < 0 || y_pos < 0) begin : g_bad_cfg
    $error("gather_credit_counter: illegal INIT_CREDIT or router coordinate");
  end

  logic [RET_W-1:0] ret_num;
  logic [32:0]      ret_add;
  logic [32:0]      sum;
  logic [32:0]      next_raw;
  logic [31:0]      cnt_nxt;
  logic [31:0]      cnt;
  logic             uf_hit;
  logic             of_hit;
  logic             low_q;
  logic             full_q;
  logic             err_uf_q;
  logic             err_of_q;

  assign ret_num  = bus.crd_ret_num;
  assign ret_add  = bus.crd_ret_valid ? 33'(ret_num) : 33'd0;
  assign sum      = {1'b0, cnt} + ret_add;
  // Underflow only when nothing at all is available this cycle, returns included.
  assign uf_hit   = bus.flit_fire && (sum == 33'd0);
  assign next_raw = sum - 33'(bus.flit_fire);
  assign of_hit   = !uf_hit && (next_raw > INIT_EXT);
  assign cnt_nxt  = uf_hit ? 32'd0 : (of_hit ? INIT_EXT[31:0] : next_raw[31:0]);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt      <= INIT_EXT[31:0];
      low_q    <= (INIT_CREDIT < LOW_WM);
      full_q   <= 1'b1;
      err_uf_q <= 1'b0;
      err_of_q <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      low_q    <= ({1'b0, cnt_nxt} < LOW_EXT);
      full_q   <= (cnt_nxt == INIT_EXT[31:0]);
      err_uf_q <= (err_uf_q & ~bus.clr_err) | uf_hit;
      err_of_q <= (err_of_q & ~bus.clr_err) | of_hit;
    end
  end

  assign bus.credit_cnt    = cnt;
  assign bus.credit_low    = low_q;
  assign bus.credit_full   = full_q;
  assign bus.err_underflow = err_uf_q;
  assign bus.err_overflow  = err_of_q;

  gather_pkt_tracker u_pkt_tracker (
    .clk        (clk),
    .rstn       (rstn),
    .flit_fire  (bus.flit_fire),
    .flit_type  (bus.flit_type),
    .clr_err    (bus.clr_err),
    .pkt_active (bus.pkt_active),
    .err_proto  (bus.err_proto)
  );

`ifdef GATHER_CRD_STATS_EN
  logic [31:0] crd_min_q;
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      crd_min_q <= INIT_EXT[31:0];
      stall_q   <= 32'd0;
    end else begin
      if (cnt_nxt < crd_min_q) crd_min_q <= cnt_nxt;
      if (low_q && !bus.pkt_active && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
    end
  end

  assign bus.crd_min      = crd_min_q;
  assign bus.stall_cycles = stall_q;
`endif

endmodule
